// File: rtl/rect_draw_scheduler.sv
// rect_draw_scheduler: shares one rectangle-draw generator between two
// requesters. Jobs are arbitrated round-robin, the generator is launched,
// and its coordinate stream is forwarded to a pixel sink tagged with the
// job owner. Each job ends with a completion pulse carrying owner, timeout
// flag and forwarded pixel count.
//
// Optional build macro: RECT_SCHED_CLIP_EN
//   When defined, pixels outside FB_WIDTH x FB_HEIGHT are suppressed and
//   counted on the clip_count output.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request, round-robin grant on req_ready
// LAUNCH | one-cycle gen_start pulse, counters cleared
// RUN    | forwarding generator coordinates, watching done/timeout
// DONE   | one-cycle job_done pulse with id/err/pixel count
module rect_draw_scheduler #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int FB_WIDTH       = 640,
  parameter int FB_HEIGHT      = 480
) (
  input  logic        _clock,
  input  logic        _reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_x,
  input  logic [63:0] req_y,
  input  logic [63:0] req_height,
  input  logic [63:0] req_width,
  output logic        gen_start,
  output logic [31:0] gen_s_x,
  output logic [31:0] gen_s_y,
  output logic [31:0] gen_height,
  output logic [31:0] gen_width,
  input  logic [31:0] gen_out0,
  input  logic [31:0] gen_out1,
  input  logic        gen_valid,
  input  logic        gen_done,
  output logic        pix_valid,
  output logic [31:0] pix_x,
  output logic [31:0] pix_y,
  output logic        pix_id,
  output logic        job_done,
  output logic        job_id,
  output logic        job_err,
  output logic [31:0] job_pixels,
  output logic        busy
`ifdef RECT_SCHED_CLIP_EN
  ,
  output logic [31:0] clip_count
`endif
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RUN,
    DONE
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic           rr_last;      // last requester served; the other wins ties
  logic           owner;
  logic [1:0]     grant;
  logic           accept;
  logic           win;
  logic [31:0]    sel_x;
  logic [31:0]    sel_y;
  logic [31:0]    sel_h;
  logic [31:0]    sel_w;
  logic           degenerate;

  logic [31:0]    pix_cnt;
  logic [CW-1:0]  cyc_cnt;
  logic [CW-1:0]  cyc_inc;
  logic           timeout_hit;
  logic           err_q;
  logic           clip_hit;
  logic           pix_take;

  // round-robin grant: a lone request wins, a tie goes to the requester not last served
  always_comb begin
    grant = 2'b00;
    if (req_valid == 2'b11) begin
      grant = rr_last ? 2'b01 : 2'b10;
    end else begin
      grant = req_valid;
    end
  end

  // reset gating keeps req_ready low while reset is held even with requests pending
  assign req_ready  = (state == IDLE && !_reset) ? grant : 2'b00;
  assign accept     = |(req_valid & req_ready);
  assign win        = req_ready[1];
  assign sel_x      = win ? req_x[63:32]      : req_x[31:0];
  assign sel_y      = win ? req_y[63:32]      : req_y[31:0];
  assign sel_h      = win ? req_height[63:32] : req_height[31:0];
  assign sel_w      = win ? req_width[63:32]  : req_width[31:0];
  assign degenerate = (sel_h == 32'd0) || (sel_w == 32'd0);

  assign cyc_inc     = cyc_cnt + CW'(1);
  assign timeout_hit = (cyc_inc == CW'(TIMEOUT_CYCLES));

`ifdef RECT_SCHED_CLIP_EN
  assign clip_hit = (gen_out0 >= 32'(FB_WIDTH)) || (gen_out1 >= 32'(FB_HEIGHT));
`else
  logic unused_fb_dims;
  assign clip_hit       = 1'b0;
  assign unused_fb_dims = (FB_WIDTH == FB_HEIGHT);
`endif

  assign pix_take = (state == RUN) && gen_valid && !clip_hit;

  // state register
  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state decode and state-derived outputs
  always_comb begin
    state_nxt  = state;
    gen_start  = 1'b0;
    job_done   = 1'b0;
    job_id     = 1'b0;
    job_err    = 1'b0;
    job_pixels = 32'd0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept) begin
          state_nxt = degenerate ? DONE : LAUNCH;
        end
      end
      LAUNCH: begin
        gen_start = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        // gen_done has priority so a job finishing on the timeout cycle is not flagged
        if (gen_done || timeout_hit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        job_done   = 1'b1;
        job_id     = owner;
        job_err    = err_q;
        job_pixels = pix_cnt;
        // an aborted generator is re-initialised with an extra start pulse
        gen_start  = err_q;
        state_nxt  = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // capture the winning job's arguments and owner, advance the round-robin pointer
  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      rr_last    <= 1'b1;
      owner      <= 1'b0;
      gen_s_x    <= 32'd0;
      gen_s_y    <= 32'd0;
      gen_height <= 32'd0;
      gen_width  <= 32'd0;
    end else if (accept) begin
      rr_last    <= win;
      owner      <= win;
      gen_s_x    <= sel_x;
      gen_s_y    <= sel_y;
      gen_height <= sel_h;
      gen_width  <= sel_w;
    end
  end

  // pixel counter, run-cycle counter and timeout flag
  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      pix_cnt <= 32'd0;
      cyc_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            pix_cnt <= 32'd0;
            cyc_cnt <= '0;
            err_q   <= 1'b0;
          end
        end
        LAUNCH: begin
          pix_cnt <= 32'd0;
          cyc_cnt <= '0;
        end
        RUN: begin
          cyc_cnt <= cyc_inc;
          if (pix_take && (pix_cnt != 32'hFFFF_FFFF)) begin
            pix_cnt <= pix_cnt + 32'd1;
          end
          if (!gen_done && timeout_hit) begin
            err_q <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // forward each accepted generator coordinate one cycle later, tagged with the owner
  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      pix_valid <= 1'b0;
      pix_x     <= 32'd0;
      pix_y     <= 32'd0;
      pix_id    <= 1'b0;
    end else begin
      pix_valid <= pix_take;
      if (pix_take) begin
        pix_x  <= gen_out0;
        pix_y  <= gen_out1;
        pix_id <= owner;
      end
    end
  end

`ifdef RECT_SCHED_CLIP_EN
  // saturating count of coordinates suppressed by the framebuffer bounds
  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      clip_count <= 32'd0;
    end else if ((state == RUN) && gen_valid && clip_hit && (clip_count != 32'hFFFF_FFFF)) begin
      clip_count <= clip_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rect_draw_scheduler.sv
// Bench for rect_draw_scheduler: a job table drives the arbiter, a small
// generator model streams raster coordinates, and a scoreboard checks the
// forwarded pixels and job completions. Hand-written sequences cover the
// timeout abort and an asynchronous reset in the middle of a job.
module tb_rect_draw_scheduler;

  localparam int TO  = 32;
  localparam int FBW = 4;
  localparam int FBH = 480;

  logic        _clock = 1'b0;
  logic        _reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_x, req_y, req_height, req_width;
  logic        gen_start;
  logic [31:0] gen_s_x, gen_s_y, gen_height, gen_width;
  logic [31:0] gen_out0, gen_out1;
  logic        gen_valid, gen_done;
  logic        pix_valid;
  logic [31:0] pix_x, pix_y;
  logic        pix_id;
  logic        job_done, job_id, job_err;
  logic [31:0] job_pixels;
  logic        busy;
`ifdef RECT_SCHED_CLIP_EN
  logic [31:0] clip_count;
`endif

  rect_draw_scheduler #(
    .TIMEOUT_CYCLES(TO),
    .FB_WIDTH(FBW),
    .FB_HEIGHT(FBH)
  ) dut (
    ._clock(_clock),
    ._reset(_reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_x(req_x),
    .req_y(req_y),
    .req_height(req_height),
    .req_width(req_width),
    .gen_start(gen_start),
    .gen_s_x(gen_s_x),
    .gen_s_y(gen_s_y),
    .gen_height(gen_height),
    .gen_width(gen_width),
    .gen_out0(gen_out0),
    .gen_out1(gen_out1),
    .gen_valid(gen_valid),
    .gen_done(gen_done),
    .pix_valid(pix_valid),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .pix_id(pix_id),
    .job_done(job_done),
    .job_id(job_id),
    .job_err(job_err),
    .job_pixels(job_pixels),
    .busy(busy)
`ifdef RECT_SCHED_CLIP_EN
    ,
    .clip_count(clip_count)
`endif
  );

  always #5 _clock = ~_clock;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        id;
  } pix_t;

  typedef struct {
    logic        id;
    logic        err;
    logic [31:0] pixels;
  } job_t;

  typedef struct {
    logic [1:0] valid;
    logic [1:0] exp_ready;
    int         x;
    int         y;
    int         h;
    int         w;
    bit         hang;
  } vec_t;

  pix_t pix_q[$];
  job_t job_q[$];
  pix_t pe;
  job_t je;
  vec_t vt[9];

  int n_chk     = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int gs_cnt    = 0;
  int done_seen = 0;
  int done_cyc  = 0;
  int exp_clip  = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  // monitor: samples 1 time unit after each rising edge and pops the scoreboard
  always begin
    @(posedge _clock);
    #1;
    cyc++;
    chk("ready_onehot", {1'b0, req_ready == 2'b11}, 2'b00);
    if (gen_start) gs_cnt++;
    if (pix_valid) begin
      if (pix_q.size() == 0) begin
        chk("pix_unexpected", pix_valid, 1'b0);
      end else begin
        pe = pix_q.pop_front();
        chk("pix_xy", {pix_x, pix_y}, {pe.x, pe.y});
        chk("pix_id", pix_id, pe.id);
      end
    end
    if (job_done) begin
      done_seen++;
      done_cyc = cyc;
      if (job_q.size() == 0) begin
        chk("job_unexpected", job_done, 1'b0);
      end else begin
        je = job_q.pop_front();
        chk("job_id", job_id, je.id);
        chk("job_err", job_err, je.err);
        chk("job_pixels", job_pixels, je.pixels);
      end
    end
  end

  task automatic set_args(input logic win, input int x, input int y, input int h, input int w);
    int wi;
    int li;
    wi = int'(win);
    li = 1 - wi;
    req_x[32*wi +: 32]      = 32'(x);
    req_y[32*wi +: 32]      = 32'(y);
    req_height[32*wi +: 32] = 32'(h);
    req_width[32*wi +: 32]  = 32'(w);
    req_x[32*li +: 32]      = 32'(x + 50);
    req_y[32*li +: 32]      = 32'(y + 60);
    req_height[32*li +: 32] = 32'd9;
    req_width[32*li +: 32]  = 32'd9;
  endtask

  // generator model: raster scan from (sx,sy), width w, idle every 4th cycle
  task automatic drive_pixels(input int sx, input int sy, input int w, input logic id,
                              input int n, input bit finish, output int cnt);
    int          k;
    int          c;
    logic [31:0] px;
    logic [31:0] py;
    bit          clipped;
    pix_t        p;
    job_t        j;
    k   = 0;
    c   = 0;
    cnt = 0;
    while (k < n) begin
      @(negedge _clock);
      if (c % 4 == 3) begin
        gen_valid = 1'b0;
        gen_done  = 1'b0;
      end else begin
        px        = 32'(sx + k % w);
        py        = 32'(sy + k / w);
        gen_valid = 1'b1;
        gen_out0  = px;
        gen_out1  = py;
        gen_done  = finish && (k == n - 1);
        clipped   = 1'b0;
`ifdef RECT_SCHED_CLIP_EN
        clipped = (px >= 32'(FBW)) || (py >= 32'(FBH));
`endif
        if (clipped) begin
          exp_clip++;
        end else begin
          p.x = px;
          p.y = py;
          p.id = id;
          pix_q.push_back(p);
          cnt++;
        end
        if (finish && (k == n - 1)) begin
          j.id = id;
          j.err = 1'b0;
          j.pixels = 32'(cnt);
          job_q.push_back(j);
        end
        k++;
      end
      c++;
    end
    @(negedge _clock);
    gen_valid = 1'b0;
    gen_done  = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_seen == d0 && n < 300) begin
      @(negedge _clock);
      n++;
    end
    chk("job_done_seen", {1'b0, done_seen != d0}, 2'b01);
  endtask

  task automatic run_vec(input vec_t v);
    logic win;
    int   gs0;
    int   d0;
    int   icyc;
    int   lcyc;
    int   cnt;
    bit   degen;
    job_t j;
    @(negedge _clock);
    win       = v.exp_ready[1];
    req_valid = v.valid;
    set_args(win, v.x, v.y, v.h, v.w);
    #1;
    chk("req_ready", req_ready, v.exp_ready);
    chk("busy_idle", busy, 1'b0);
    gs0   = gs_cnt;
    d0    = done_seen;
    icyc  = cyc;
    degen = (v.h == 0) || (v.w == 0);
    if (degen) begin
      j.id = win;
      j.err = 1'b0;
      j.pixels = 32'd0;
      job_q.push_back(j);
    end
    @(negedge _clock);
    chk("busy_active", busy, 1'b1);
    if (degen) begin
      wait_done(d0);
      chk("degen_latency", done_cyc, icyc + 1);
      chk("degen_no_start", gs_cnt - gs0, 0);
    end else begin
      lcyc = cyc;
      chk("launch_start", gen_start, 1'b1);
      chk("launch_xy", {gen_s_x, gen_s_y}, {32'(v.x), 32'(v.y)});
      chk("launch_hw", {gen_height, gen_width}, {32'(v.h), 32'(v.w)});
      // stray generator activity during LAUNCH must be ignored
      gen_valid = 1'b1;
      gen_done  = 1'b1;
      gen_out0  = 32'hDEAD_BEEF;
      gen_out1  = 32'hDEAD_BEEF;
      if (v.hang) begin
        drive_pixels(v.x, v.y, v.w, win, 3, 1'b0, cnt);
        j.id = win;
        j.err = 1'b1;
        j.pixels = 32'(cnt);
        job_q.push_back(j);
        wait_done(d0);
        chk("timeout_latency", done_cyc - lcyc, TO + 1);
        chk("abort_start_count", gs_cnt - gs0, 2);
      end else begin
        drive_pixels(v.x, v.y, v.w, win, v.h * v.w, 1'b1, cnt);
        wait_done(d0);
        chk("start_count", gs_cnt - gs0, 1);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int   cnt;
    vec_t fin;

    vt[0] = '{2'b11, 2'b01, 2,  3,  4, 5, 1'b0};
    vt[1] = '{2'b11, 2'b10, 10, 20, 2, 3, 1'b0};
    vt[2] = '{2'b11, 2'b01, 0,  0,  1, 7, 1'b0};
    vt[3] = '{2'b10, 2'b10, 8,  8,  0, 5, 1'b0};
    vt[4] = '{2'b01, 2'b01, 6,  6,  3, 0, 1'b0};
    vt[5] = '{2'b11, 2'b10, 5,  5,  1, 1, 1'b0};
    vt[6] = '{2'b11, 2'b01, 1,  1,  8, 8, 1'b1};
    vt[7] = '{2'b11, 2'b10, 7,  9,  2, 2, 1'b0};
    vt[8] = '{2'b01, 2'b01, 3,  4,  1, 3, 1'b0};
    fin   = '{2'b11, 2'b01, 1,  2,  1, 2, 1'b0};

    _reset     = 1'b1;
    req_valid  = 2'b11;
    req_x      = 64'h0000_0011_0000_0022;
    req_y      = 64'h0000_0033_0000_0044;
    req_height = 64'h0000_0005_0000_0005;
    req_width  = 64'h0000_0005_0000_0005;
    gen_out0   = 32'd0;
    gen_out1   = 32'd0;
    gen_valid  = 1'b0;
    gen_done   = 1'b0;

    repeat (2) @(negedge _clock);
    #1;
    chk("reset_ctrl", {busy, gen_start, pix_valid, job_done, job_id, job_err, pix_id, req_ready}, 9'd0);
    chk("reset_data", {gen_s_x, gen_height, pix_x, job_pixels}, 128'd0);
    @(negedge _clock);
    _reset    = 1'b0;
    req_valid = 2'b00;

    for (int i = 0; i < 9; i++) begin
      run_vec(vt[i]);
    end

    // asynchronous reset in the middle of a req0 job, with a pixel in flight
    @(negedge _clock);
    req_valid = 2'b01;
    set_args(1'b0, 0, 0, 2, 4);
    #1;
    chk("rst_job_ready", req_ready, 2'b01);
    @(negedge _clock);
    chk("rst_job_launch", gen_start, 1'b1);
    drive_pixels(0, 0, 4, 1'b0, 3, 1'b0, cnt);
    chk("rst_job_inflight", pix_valid, 1'b1);
`ifdef RECT_SCHED_CLIP_EN
    chk("clip_count", clip_count, 32'(exp_clip));
`endif
    req_valid = 2'b11;
    #2;
    _reset = 1'b1;
    #1;
    chk("async_reset_ctrl", {busy, gen_start, pix_valid, job_done, job_id, job_err, pix_id, req_ready}, 9'd0);
    chk("async_reset_gen", {gen_s_x, gen_s_y, gen_height, gen_width}, 128'd0);
    chk("async_reset_pix", {pix_x, pix_y, job_pixels}, 96'd0);
`ifdef RECT_SCHED_CLIP_EN
    chk("clip_reset", clip_count, 32'd0);
    exp_clip = 0;
`endif
    @(negedge _clock);
    _reset    = 1'b0;
    req_valid = 2'b00;

    // after reset requester 0 has priority again and counters start from zero
    run_vec(fin);

    repeat (3) @(negedge _clock);
    chk("pix_queue_empty", pix_q.size(), 0);
    chk("job_queue_empty", job_q.size(), 0);
`ifdef RECT_SCHED_CLIP_EN
    chk("clip_count_final", clip_count, 32'(exp_clip));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
